frame_arbiter: RTL and testbench

Round-robin frame-level arbiter that shares one downstream 64-bit framed stream among `N_CH` per-channel framer outputs; each framer emits header, data and footer words. A grant is held from the first accepted word of a frame until its `TLAST` word is accepted, so frames are never interleaved. The arbiter sits between the per-channel header/footer stages and the single readout FIFO/DMA path. Optionally, a stalled frame is terminated with an abort footer.

---
 rtl/frame_arbiter.sv | 149 ++++++++++++++
 tb/tb_frame_arbiter.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_arbiter.sv
// Round-robin frame arbiter: merges N_CH framed streams, holding each grant until TLAST is accepted.
// Optional FRAME_TIMEOUT_EN: a granted source idle for TIMEOUT_CYCLES gets an abort footer and its remainder flushed.
module frame_arbiter #(
  parameter int N_CH           = 4,
  parameter int DATA_WIDTH     = 64,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                         CLK,
  input  logic                         RESETN,
  input  logic [N_CH*DATA_WIDTH-1:0]   S_TDATA,
  input  logic [N_CH-1:0]              S_TVALID,
  input  logic [N_CH-1:0]              S_TLAST,
  output logic [N_CH-1:0]              S_TREADY,
  output logic [DATA_WIDTH-1:0]        M_TDATA,
  output logic                         M_TVALID,
  output logic                         M_TLAST,
  input  logic                         M_TREADY,
  output logic [$clog2(N_CH)-1:0]      GRANT_ID,
  output logic                         BUSY,
  output logic [31:0]                  FRAME_CNT,
  output logic [15:0]                  ABORT_CNT
);
  localparam int GW = $clog2(N_CH);

  typedef enum logic [1:0] {IDLE, GRANT, ABORT, FLUSH} state_t;

  state_t                state;
  logic [GW-1:0]         last_grant;
  logic [GW-1:0]         sel;
  logic                  vld_g;
  logic                  last_g;
  logic                  hs_g;
  logic [DATA_WIDTH-1:0] s_word [N_CH];

  for (genvar k = 0; k < N_CH; k++) begin : g_unpack
    assign s_word[k] = S_TDATA[k*DATA_WIDTH +: DATA_WIDTH];
  end

  assign vld_g  = S_TVALID[GRANT_ID];
  assign last_g = S_TLAST[GRANT_ID];
  assign hs_g   = vld_g & M_TREADY;
  assign BUSY   = (state != IDLE);

  // First requester after last_grant wins, so the previous owner has lowest priority.
  always_comb begin : rr_select
    int   idx;
    logic found;
    idx   = 0;
    found = 1'b0;
    sel   = last_grant;
    for (int i = 1; i <= N_CH; i++) begin
      idx = (int'(last_grant) + i) % N_CH;
      if (!found && S_TVALID[GW'(idx)]) begin
        found = 1'b1;
        sel   = GW'(idx);
      end
    end
  end

  always_comb begin
    M_TDATA  = '0;
    M_TVALID = 1'b0;
    M_TLAST  = 1'b0;
    S_TREADY = '0;
    case (state)
      GRANT: begin
        M_TDATA            = s_word[GRANT_ID];
        M_TVALID           = vld_g;
        M_TLAST            = last_g;
        S_TREADY[GRANT_ID] = M_TREADY;
      end
`ifdef FRAME_TIMEOUT_EN
      ABORT: begin
        M_TDATA  = {8'hEE, 8'(GRANT_ID), {(DATA_WIDTH-16){1'b0}}};
        M_TVALID = 1'b1;
        M_TLAST  = 1'b1;
      end
      FLUSH: S_TREADY[GRANT_ID] = 1'b1;
`endif
      default: ;
    endcase
  end

`ifdef FRAME_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] to_cnt;
`else
  // TIMEOUT_CYCLES only matters for the timeout build.
  assign ABORT_CNT = 16'(0 * TIMEOUT_CYCLES);
`endif

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      state      <= IDLE;
      GRANT_ID   <= GW'(N_CH - 1);
      last_grant <= GW'(N_CH - 1);
      FRAME_CNT  <= '0;
`ifdef FRAME_TIMEOUT_EN
      ABORT_CNT  <= '0;
      to_cnt     <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (|S_TVALID) begin
            GRANT_ID <= sel;
            state    <= GRANT;
`ifdef FRAME_TIMEOUT_EN
            to_cnt   <= '0;
`endif
          end
        end
        GRANT: begin
          if (hs_g) begin
`ifdef FRAME_TIMEOUT_EN
            to_cnt <= '0;
`endif
            if (last_g) begin
              FRAME_CNT  <= FRAME_CNT + 32'd1;
              last_grant <= GRANT_ID;
              state      <= IDLE;
            end
          end
`ifdef FRAME_TIMEOUT_EN
          // Only a silent source counts; downstream backpressure never aborts.
          else if (!vld_g) begin
            to_cnt <= to_cnt + TW'(1);
            if (to_cnt == TW'(TIMEOUT_CYCLES - 1)) state <= ABORT;
          end
`endif
        end
`ifdef FRAME_TIMEOUT_EN
        ABORT: begin
          if (M_TREADY) begin
            if (ABORT_CNT != 16'hFFFF) ABORT_CNT <= ABORT_CNT + 16'd1;
            last_grant <= GRANT_ID;
            state      <= FLUSH;
          end
        end
        FLUSH: begin
          if (vld_g && last_g) state <= IDLE;
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_frame_arbiter.sv
// Directed bench for frame_arbiter: ordering, bubbles, backpressure, async reset, stall/abort.
module tb_frame_arbiter;
  localparam int N  = 4;
  localparam int DW = 64;

  logic            CLK = 1'b0;
  logic            RESETN;
  logic [N*DW-1:0] S_TDATA;
  logic [N-1:0]    S_TVALID;
  logic [N-1:0]    S_TLAST;
  logic [N-1:0]    S_TREADY;
  logic [DW-1:0]   M_TDATA;
  logic            M_TVALID;
  logic            M_TLAST;
  logic            M_TREADY;
  logic [1:0]      GRANT_ID;
  logic            BUSY;
  logic [31:0]     FRAME_CNT;
  logic [15:0]     ABORT_CNT;

  frame_arbiter #(.N_CH(N), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(16)) dut (
    .CLK(CLK), .RESETN(RESETN),
    .S_TDATA(S_TDATA), .S_TVALID(S_TVALID), .S_TLAST(S_TLAST), .S_TREADY(S_TREADY),
    .M_TDATA(M_TDATA), .M_TVALID(M_TVALID), .M_TLAST(M_TLAST), .M_TREADY(M_TREADY),
    .GRANT_ID(GRANT_ID), .BUSY(BUSY), .FRAME_CNT(FRAME_CNT), .ABORT_CNT(ABORT_CNT)
  );

  always #5 CLK = ~CLK;

  int tests = 0;
  int fails = 0;
  bit act[N];
  bit stall[N];
  int pos[N];
  int len[N];
  int nfr[N];
  int fseq[N];
  logic [63:0] exp_q[$];
  bit sb_en = 1'b1;
  int cyc = 0;
  int first_hs = -1;
  int last_hs = 0;
  int exp_abort = 0;

  function automatic logic [63:0] word(int k, int f, int p);
    return {8'(k), 8'(f), 40'h0, 8'(p)};
  endfunction

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic expect_words(int k, int f, int n);
    for (int p = 0; p < n; p++) exp_q.push_back(word(k, f, p));
  endtask

  task automatic start(int k, int l, int n);
    act[k] = 1'b1; len[k] = l; nfr[k] = n; pos[k] = 0;
  endtask

  function automatic bit any_act();
    bit a = 1'b0;
    for (int k = 0; k < N; k++) a |= act[k];
    return a;
  endfunction

  // Present each channel's current word, then let outputs settle.
  task automatic drive();
    for (int k = 0; k < N; k++) begin
      S_TVALID[k]          = act[k] && !stall[k];
      S_TLAST[k]           = (pos[k] == len[k] - 1);
      S_TDATA[k*DW +: DW]  = word(k, fseq[k], pos[k]);
    end
    #1;
  endtask

  task automatic adv();
    logic [N-1:0] hs;
    hs = S_TVALID & S_TREADY;
    if (M_TVALID && M_TREADY) begin
      if (first_hs < 0) first_hs = cyc;
      last_hs = cyc;
      if (sb_en) begin
        tests++;
        assert (exp_q.size() != 0) else begin
          fails++;
          $error("FAIL sb_extra_word: observed %0h expected no word", M_TDATA);
        end
        if (exp_q.size() != 0) chk("sb_word", M_TDATA, exp_q.pop_front());
      end
    end
    @(posedge CLK);
    cyc++;
    for (int k = 0; k < N; k++) begin
      if (hs[k]) begin
        if (pos[k] == len[k] - 1) begin
          pos[k] = 0; fseq[k]++; nfr[k]--;
          if (nfr[k] == 0) act[k] = 1'b0;
        end else begin
          pos[k]++;
        end
      end
    end
    @(negedge CLK);
  endtask

  task automatic step();
    drive();
    adv();
  endtask

  task automatic drain(string tag, int budget);
    int n = 0;
    while (n < budget) begin
      drive();
      if (exp_q.size() == 0 && !any_act()) break;
      adv();
      n++;
    end
    chk({"drain_q_", tag}, 64'(exp_q.size()), 64'd0);
    chk({"drain_src_", tag}, {63'b0, any_act()}, 64'd0);
  endtask

  initial begin
    RESETN = 1'b0; M_TREADY = 1'b1;
    S_TDATA = '0; S_TVALID = '0; S_TLAST = '0;
    for (int k = 0; k < N; k++) begin
      act[k] = 0; stall[k] = 0; pos[k] = 0; len[k] = 1; nfr[k] = 0; fseq[k] = 0;
    end
    repeat (2) @(negedge CLK);
    RESETN = 1'b1;
    drive();
    chk("rst_m_tvalid", M_TVALID, 0);
    chk("rst_m_tlast", M_TLAST, 0);
    chk("rst_m_tdata", M_TDATA, 0);
    chk("rst_s_tready", S_TREADY, 0);
    chk("rst_grant_id", GRANT_ID, 3);
    chk("rst_busy", BUSY, 0);
    chk("rst_frame_cnt", FRAME_CNT, 0);
    chk("rst_abort_cnt", ABORT_CNT, 0);

    // All four channels request together: order 0..3, one bubble between frames.
    for (int k = 0; k < N; k++) begin
      start(k, 8, 1);
      expect_words(k, fseq[k], 8);
    end
    first_hs = -1;
    drive();
    chk("t1_idle_valid", M_TVALID, 0);
    chk("t1_idle_busy", BUSY, 0);
    adv();
    drive();
    chk("t1_first_grant", GRANT_ID, 0);
    chk("t1_first_valid", M_TVALID, 1);
    chk("t1_first_word", M_TDATA, word(0, 0, 0));
    adv();
    drain("t1", 200);
    chk("t1_span", 64'(last_hs - first_hs), 64'd34);
    chk("t1_frame_cnt", FRAME_CNT, 4);

    // ch2 streams back to back; ch1 arrives mid-frame and must win the next slot.
    expect_words(2, fseq[2], 8);
    expect_words(1, fseq[1], 4);
    expect_words(2, fseq[2] + 1, 8);
    start(2, 8, 2);
    repeat (5) step();
    start(1, 4, 1);
    drain("t2", 200);
    chk("t2_frame_cnt", FRAME_CNT, 7);

    // 50-word frame under random backpressure: S_TREADY[0] tracks M_TREADY.
    expect_words(0, fseq[0], 50);
    start(0, 50, 1);
    step();
    begin
      int n = 0;
      while (act[0] && n < 1000) begin
        M_TREADY = 1'($urandom_range(0, 1));
        drive();
        chk("t3_tready_mirror", S_TREADY, {3'b0, M_TREADY});
        adv();
        n++;
      end
    end
    M_TREADY = 1'b1;
    drain("t3", 10);
    chk("t3_frame_cnt", FRAME_CNT, 8);

    // Asynchronous reset while word 5 of a ch1 frame is on the bus.
    expect_words(1, fseq[1], 4);
    start(1, 8, 1);
    step();
    repeat (4) step();
    drive();
    chk("t4_word5", M_TDATA, word(1, fseq[1], 4));
    RESETN = 1'b0;
    #1;
    chk("t4_rst_m_tvalid", M_TVALID, 0);
    chk("t4_rst_m_tdata", M_TDATA, 0);
    chk("t4_rst_m_tlast", M_TLAST, 0);
    chk("t4_rst_s_tready", S_TREADY, 0);
    chk("t4_rst_busy", BUSY, 0);
    chk("t4_rst_grant_id", GRANT_ID, 3);
    chk("t4_rst_frame_cnt", FRAME_CNT, 0);
    exp_q.delete();
    for (int k = 0; k < N; k++) pos[k] = 0;
    @(negedge CLK);
    RESETN = 1'b1;
    expect_words(0, fseq[0], 3);
    expect_words(1, fseq[1], 8);
    start(0, 3, 1);
    drain("t4", 100);
    chk("t4_frame_cnt", FRAME_CNT, 2);

    // ch3 goes silent after 3 words while ch0 waits.
`ifdef FRAME_TIMEOUT_EN
    expect_words(3, fseq[3], 3);
`else
    expect_words(3, fseq[3], 6);
`endif
    start(3, 6, 1);
    step();
    repeat (3) step();
    stall[3] = 1'b1;
    expect_words(0, fseq[0], 2);
    start(0, 2, 1);
`ifdef FRAME_TIMEOUT_EN
    repeat (16) step();
    drive();
    chk("t5_abort_word", M_TDATA, 64'hEE03_0000_0000_0000);
    chk("t5_abort_last", M_TLAST, 1);
    chk("t5_abort_valid", M_TVALID, 1);
    sb_en = 1'b0;
    adv();
    sb_en = 1'b1;
    exp_abort = 1;
    drive();
    chk("t5_abort_cnt", ABORT_CNT, 1);
    chk("t5_flush_busy", BUSY, 1);
    stall[3] = 1'b0;
    drain("t5", 100);
    chk("t5_frame_cnt", FRAME_CNT, 3);
`else
    repeat (40) step();
    drive();
    chk("t5_stall_busy", BUSY, 1);
    chk("t5_stall_grant", GRANT_ID, 3);
    chk("t5_stall_valid", M_TVALID, 0);
    chk("t5_abort_cnt", ABORT_CNT, 0);
    stall[3] = 1'b0;
    drain("t5", 100);
    chk("t5_frame_cnt", FRAME_CNT, 4);
`endif

    // Long downstream backpressure with the source valid never aborts.
    expect_words(1, fseq[1], 4);
    start(1, 4, 1);
    M_TREADY = 1'b0;
    repeat (101) step();
    drive();
    chk("t6_hold_valid", M_TVALID, 1);
    chk("t6_hold_word", M_TDATA, word(1, fseq[1], 0));
    chk("t6_hold_busy", BUSY, 1);
    chk("t6_abort_cnt", ABORT_CNT, 64'(exp_abort));
    M_TREADY = 1'b1;
    drain("t6", 50);
`ifdef FRAME_TIMEOUT_EN
    chk("t6_frame_cnt", FRAME_CNT, 4);
`else
    chk("t6_frame_cnt", FRAME_CNT, 5);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
